// File: rtl/sseg_scan_controller.sv
// Seven-segment scan controller for common-anode digits that share one decoder.
// It time-multiplexes the digits with a dead-time gap at the start of each slot.
// Display contents are double-buffered and swapped only at a frame boundary,
// or immediately when scanning is disabled.
module sseg_scan_controller #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int DEAD_TICKS      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    input  logic                    wr_lzb,
    output logic [3:0]              nibble,
    output logic                    blank,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done,
    output logic                    upd_done
);

    localparam int CW = $clog2(TICKS_PER_DIGIT);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_TICKS - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [DW-1:0] D_LAST    = DW'(NUM_DIGITS - 1);

    typedef enum logic {S_DEAD, S_ON} state_t;

    state_t                         state;
    logic [DW-1:0]                  d;
    logic [CW-1:0]                  cnt;

    logic [NUM_DIGITS-1:0][3:0]     act_data, shd_data;
    logic [NUM_DIGITS-1:0]          act_blank, shd_blank;
    logic                           act_lzb, shd_lzb;
    logic                           pending;

    logic [NUM_DIGITS-1:0]          lz;
    logic                           zero_above;
    logic                           apply;

    // The shadow set is copied over at the end of a frame, or immediately when scanning is stopped.
    assign apply    = pending & (frame_done | ~en);
    assign wr_ready = ~pending;

    // Scan FSM: DEAD gap, then ON, per digit slot. It is held in DEAD at digit 0 while disabled.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state <= S_DEAD;
            d     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_DEAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == DEAD_LAST) state <= S_ON;
                end
                S_ON: begin
                    if (cnt == SLOT_LAST) begin
                        cnt   <= '0;
                        state <= S_DEAD;
                        d     <= (d == D_LAST) ? '0 : d + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_DEAD;
            endcase
        end
    end

    // Double buffer: accept into the shadow set, then apply to the active set and pulse upd_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_data  <= '0;
            act_blank <= '0;
            act_lzb   <= 1'b0;
            shd_data  <= '0;
            shd_blank <= '0;
            shd_lzb   <= 1'b0;
            pending   <= 1'b0;
            upd_done  <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            if (apply) begin
                act_data  <= shd_data;
                act_blank <= shd_blank;
                act_lzb   <= shd_lzb;
                pending   <= 1'b0;
                upd_done  <= 1'b1;
            end else if (wr_valid && !pending) begin
                shd_data  <= wr_data;
                shd_blank <= wr_blank;
                shd_lzb   <= wr_lzb;
                pending   <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i is blanked when it and every higher digit are zero. Digit 0 is never blanked.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (act_data[i] == 4'h0);
            lz[i]      = act_lzb & zero_above;
        end
    end

    // Output decode from the registered scan state and the active set only.
    always_comb begin
        digit_en_n = '1;
        nibble     = 4'h0;
        blank      = 1'b1;
        if (state == S_ON) begin
            digit_en_n[d] = 1'b0;
            nibble        = act_data[d];
            blank         = act_blank[d] | lz[d];
        end
    end

    assign frame_done = (state == S_ON) && (cnt == SLOT_LAST) && (d == D_LAST);

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller (4 digits, 8 ticks per slot, 2 dead ticks).
// The stimulus queues expected observations keyed by cycle.
// A negedge monitor pops each observation and compares it when its cycle arrives.
module tb_sseg_scan_controller;

    localparam int N   = 4;
    localparam int TPD = 8;
    localparam int DT  = 2;

    localparam int S_DEN = 0, S_BLK = 1, S_NIB = 2, S_FD = 3, S_UD = 4, S_RDY = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           wr_valid;
    logic           wr_ready;
    logic [4*N-1:0] wr_data;
    logic [N-1:0]   wr_blank;
    logic           wr_lzb;
    logic [3:0]     nibble;
    logic           blank;
    logic [N-1:0]   digit_en_n;
    logic           frame_done;
    logic           upd_done;

    sseg_scan_controller #(
        .NUM_DIGITS(N), .TICKS_PER_DIGIT(TPD), .DEAD_TICKS(DT)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_blank(wr_blank), .wr_lzb(wr_lzb),
        .nibble(nibble), .blank(blank), .digit_en_n(digit_en_n),
        .frame_done(frame_done), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t keep_q[$];
    int   base   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [15:0] probe(int sel);
        case (sel)
            S_DEN:   return {12'h0, digit_en_n};
            S_BLK:   return {15'h0, blank};
            S_NIB:   return {12'h0, nibble};
            S_FD:    return {15'h0, frame_done};
            S_UD:    return {15'h0, upd_done};
            S_RDY:   return {15'h0, wr_ready};
            default: return 16'h0;
        endcase
    endfunction

    task automatic expect_abs(int at, string tag, int sel, logic [15:0] val);
        exp_t e;
        e.at = at; e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic ex(int rel, string tag, int sel, logic [15:0] val);
        expect_abs(base + rel, tag, sel, val);
    endtask

    // Digit enables, nibble and blank together for one scan cycle.
    task automatic scan(int rel, string tag, logic [3:0] den, logic [3:0] nib, logic blk);
        ex(rel, {tag, ".den"}, S_DEN, {12'h0, den});
        ex(rel, {tag, ".nib"}, S_NIB, {12'h0, nib});
        ex(rel, {tag, ".blank"}, S_BLK, {15'h0, blk});
    endtask

    task automatic goto(int rel);
        while (cyc < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_at(int rel, logic [15:0] data, logic lzb);
        goto(rel);
        wr_valid = 1'b1; wr_data = data; wr_blank = '0; wr_lzb = lzb;
        goto(rel + 1);
        wr_valid = 1'b0;
    endtask

    // Monitor: compare every expectation due in this cycle; anything overdue was never seen.
    always @(negedge clk) begin
        keep_q = {};
        foreach (sb[i]) begin
            if (sb[i].at == cyc) begin
                n_chk++;
                if (probe(sb[i].sel) !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got %0h expected %0h",
                             sb[i].tag, cyc - base, probe(sb[i].sel), sb[i].val);
                end
            end else if (sb[i].at < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].tag, sb[i].at - base);
            end else begin
                keep_q.push_back(sb[i]);
            end
        end
        sb = keep_q;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_blank = '0; wr_lzb = 1'b0;
        // Reset state is sampled while reset is still held.
        expect_abs(2, "rst.den", S_DEN, 16'hF);
        expect_abs(2, "rst.blank", S_BLK, 16'h1);
        expect_abs(2, "rst.nib", S_NIB, 16'h0);
        expect_abs(2, "rst.fd", S_FD, 16'h0);
        expect_abs(2, "rst.ud", S_UD, 16'h0);
        expect_abs(2, "rst.rdy", S_RDY, 16'h1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;

        // First scan after reset.
        scan(0, "s0", 4'hF, 4'h0, 1'b1);
        ex(0, "s0.rdy", S_RDY, 16'h1);
        ex(1, "s1.den", S_DEN, 16'hF);
        ex(1, "s1.blank", S_BLK, 16'h1);
        ex(2, "s2.den", S_DEN, 16'hE);
        ex(7, "s7.den", S_DEN, 16'hE);
        ex(8, "s8.den", S_DEN, 16'hF);
        ex(10, "s10.den", S_DEN, 16'hD);
        ex(15, "s15.den", S_DEN, 16'hD);
        ex(30, "fd30", S_FD, 16'h0);
        ex(31, "fd31", S_FD, 16'h1);
        ex(32, "fd32", S_FD, 16'h0);

        // Update 1234 applied at the frame boundary.
        ex(5, "u.rdy5", S_RDY, 16'h1);
        ex(6, "u.rdy6", S_RDY, 16'h0);
        ex(31, "u.rdy31", S_RDY, 16'h0);
        ex(31, "u.ud31", S_UD, 16'h0);
        ex(32, "u.ud32", S_UD, 16'h1);
        ex(32, "u.rdy32", S_RDY, 16'h1);
        ex(33, "u.ud33", S_UD, 16'h0);
        ex(7, "u.nib7", S_NIB, 16'h0);
        ex(31, "u.nib31", S_NIB, 16'h0);
        scan(34, "u.d0", 4'hE, 4'h4, 1'b0);
        scan(39, "u.d0e", 4'hE, 4'h4, 1'b0);
        scan(42, "u.d1", 4'hD, 4'h3, 1'b0);
        scan(50, "u.d2", 4'hB, 4'h2, 1'b0);
        scan(58, "u.d3", 4'h7, 4'h1, 1'b0);
        ex(63, "fd63", S_FD, 16'h1);
        write_at(5, 16'h1234, 1'b0);

        // Leading-zero blanking: 0050, then 0000.
        ex(64, "lz.ud64", S_UD, 16'h1);
        scan(66, "lz.d0", 4'hE, 4'h0, 1'b0);
        scan(74, "lz.d1", 4'hD, 4'h5, 1'b0);
        scan(82, "lz.d2", 4'hB, 4'h0, 1'b1);
        scan(90, "lz.d3", 4'h7, 4'h0, 1'b1);
        scan(98, "lz0.d0", 4'hE, 4'h0, 1'b0);
        scan(106, "lz0.d1", 4'hD, 4'h0, 1'b1);
        scan(114, "lz0.d2", 4'hB, 4'h0, 1'b1);
        scan(122, "lz0.d3", 4'h7, 4'h0, 1'b1);
        write_at(40, 16'h0050, 1'b1);
        write_at(70, 16'h0000, 1'b1);

        // Backpressure: AAAA accepted, BBBB held until the next ready window.
        ex(100, "bp.rdy100", S_RDY, 16'h1);
        ex(101, "bp.rdy101", S_RDY, 16'h0);
        ex(127, "bp.rdy127", S_RDY, 16'h0);
        ex(128, "bp.ud128", S_UD, 16'h1);
        ex(128, "bp.rdy128", S_RDY, 16'h1);
        ex(129, "bp.rdy129", S_RDY, 16'h0);
        scan(130, "bp.a0", 4'hE, 4'hA, 1'b0);
        scan(154, "bp.a3", 4'h7, 4'hA, 1'b0);
        ex(160, "bp.ud160", S_UD, 16'h1);
        scan(162, "bp.b0", 4'hE, 4'hB, 1'b0);
        scan(186, "bp.b3", 4'h7, 4'hB, 1'b0);
        goto(100);
        wr_valid = 1'b1; wr_data = 16'hAAAA; wr_blank = '0; wr_lzb = 1'b0;
        goto(101);
        wr_data = 16'hBBBB;
        goto(129);
        wr_valid = 1'b0;

        // Disable during digit 2 ON with an update pending, then a write while disabled.
        scan(210, "dis.d2", 4'hB, 4'hB, 1'b0);
        ex(211, "dis.den211", S_DEN, 16'hB);
        scan(212, "dis.off", 4'hF, 4'h0, 1'b1);
        ex(212, "dis.ud212", S_UD, 16'h1);
        ex(212, "dis.rdy212", S_RDY, 16'h1);
        ex(216, "dis.rdy216", S_RDY, 16'h0);
        ex(216, "dis.ud216", S_UD, 16'h0);
        ex(217, "dis.ud217", S_UD, 16'h1);
        ex(217, "dis.rdy217", S_RDY, 16'h1);
        ex(219, "dis.den219", S_DEN, 16'hF);
        scan(220, "re.dead0", 4'hF, 4'h0, 1'b1);
        ex(221, "re.dead1", S_DEN, 16'hF);
        scan(222, "re.on", 4'hE, 4'h9, 1'b0);
        write_at(200, 16'h1357, 1'b0);
        goto(211);
        en = 1'b0;
        write_at(215, 16'h0009, 1'b0);
        goto(220);
        en = 1'b1;

        // Reset during digit 1 ON with FFFF pending.
        ex(226, "mr.rdy226", S_RDY, 16'h0);
        ex(231, "mr.rdy231", S_RDY, 16'h0);
        scan(232, "mr.rst", 4'hF, 4'h0, 1'b1);
        ex(232, "mr.rdy", S_RDY, 16'h1);
        ex(232, "mr.ud", S_UD, 16'h0);
        ex(232, "mr.fd", S_FD, 16'h0);
        ex(233, "mr.rdy233", S_RDY, 16'h1);
        ex(233, "mr.den233", S_DEN, 16'hF);
        ex(234, "mr.den234", S_DEN, 16'hF);
        scan(235, "mr.d0", 4'hE, 4'h0, 1'b0);
        scan(243, "mr.d1", 4'hD, 4'h0, 1'b0);
        ex(263, "mr.fd263", S_FD, 16'h0);
        ex(264, "mr.fd264", S_FD, 16'h1);
        ex(265, "mr.ud265", S_UD, 16'h0);
        scan(267, "mr.d0n", 4'hE, 4'h0, 1'b0);
        write_at(225, 16'hFFFF, 1'b0);
        goto(231);
        reset = 1'b1;
        goto(233);
        reset = 1'b0;

        goto(272);
        @(negedge clk);
        #1;
        foreach (sb[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb[i].tag, sb[i].at - base);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
